wave_prefetch: RTL
==================

Name: wave_prefetch

Overview:
- Streams 8-bit unsigned PCM sample bytes out of DDR3 and sits between the ddram word port and the wave playback / audio output path.
- Fetches 64-bit words ahead of playback into a small word FIFO, then unpacks one byte per sample tick.
- Converts each byte to a signed 16-bit sample for AUDIO_L/AUDIO_R.
- Hides DDR latency so the player never stalls on a per-byte read handshake.

Parameters:
- FIFO_WORDS, 4, depth of the 64-bit word FIFO; must be a power of two, minimum 2.
- DIV_W, 16, width of the sample-rate divider.

Ports:
- clk_sys  in  1  system clock (24 MHz).
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; latches start_addr and length, then begins playback.
- stop  in  1  one-cycle pulse; aborts playback.
- start_addr  in  28  byte address of the first sample; any alignment allowed.
- length  in  24  number of sample bytes; 0 means no-op.
- rate_div  in  DIV_W  clk_sys cycles per sample minus 1 (2999 gives 8 kHz).
- mem_rd  out  1  word read request, held until accepted.
- mem_addr  out  25  word address (byte address bits 27:3).
- mem_busy  in  1  memory not accepting; a request is accepted on a cycle with mem_rd=1 and mem_busy=0.
- mem_dout  in  64  read data; byte 0 is in bits 7:0.
- mem_valid  in  1  mem_dout valid for one cycle.
- sample  out  16  signed sample, held between ticks.
- sample_stb  out  1  one-cycle pulse when sample updates.
- playing  out  1  high from start until the last byte is emitted or the block aborts.
- done  out  1  one-cycle pulse after the last byte is emitted.
- underrun  out  1  sticky; set when a tick finds the FIFO empty while bytes remain. Cleared by start.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, FIFO empty, divider 0.
- Fetch FSM states: IDLE, REQ, WAIT.
  - IDLE→REQ on start with length≠0.
  - REQ: assert mem_rd with mem_addr = current word. On acceptance go to WAIT.
  - WAIT: on mem_valid, push the word and increment the word address.
    - Go to REQ if words remain and a FIFO slot is free after the push.
    - Otherwise go to IDLE-fetch (fetch side parked).
  - Parked fetch side re-enters REQ once a slot frees.
- Exactly one outstanding read at any time.
- Fetch count: words fetched = ((start_addr[2:0] + length + 7) >> 3). The fetcher never reads beyond the last word.
- Unpack side:
  - Byte index starts at start_addr[2:0] for the first word and at 0 for later words.
  - A word pops when byte index 7 is consumed or when the final byte is consumed.
- Divider:
  - Counts 0..rate_div while playing and produces a tick at the terminal count.
  - The first tick comes rate_div+1 cycles after start.
- On tick with FIFO non-empty:
  - sample <= {~byte[7], byte[6:0], 8'h00}.
  - sample_stb pulses the next cycle; remaining count decrements.
- On tick with FIFO empty and bytes remaining: sample is held, no sample_stb, underrun<=1, and the byte stays pending for the next tick.
- Last byte emitted:
  - playing<=0 and done pulses in the same cycle as sample_stb.
  - sample holds its final value.
- stop (or start while playing) flushes the FIFO and resets the divider.
  - A read already in flight is still absorbed: the fetch side waits for its mem_valid and discards it.
  - A new start is only accepted once no read is outstanding; until then it is latched as pending.
  - stop sets playing<=0 with no done pulse.
- start and stop in the same cycle: stop wins and the start is dropped.
- Address wrap: word address increments modulo 2^25.
- Length arithmetic: 24-bit, so the 24-bit remaining-byte counter is sufficient.
- mem_valid arriving while not in WAIT and not draining is ignored.

Decomposition:
- Shared package wave_pkg holds:
  - fetch state enum (IDLE, REQ, WAIT);
  - localparam BYTES_PER_WORD=8;
  - function u8_to_s16 for the byte-to-sample conversion.
- One sub-module, wave_word_fifo: synchronous FIFO, width 64, depth FIFO_WORDS, with full, empty and level outputs. First-word fall-through so the unpacker reads the head combinationally.

Test Plan:
1. Aligned playback: start_addr=0x100, length=16, rate_div=9, memory bytes 0x00..0x0F, mem_valid 3 cycles after accept → exactly 2 reads (mem_addr 0x20, 0x21). Sample sequence 0x8000, 0x8100, …, 0x8F00 with 10-cycle spacing. done pulse with the 16th strobe.
2. Unaligned short: start_addr=0x105, length=5 → reads 0x20, 0x21. Bytes emitted are mem offsets 5, 6, 7, 8, 9. No third read.
3. Underrun: mem_busy held high for 200 cycles, rate_div=9 → underrun=1, no sample_stb during the stall. Playback resumes with the first byte once memory is released. underrun clears only on the next start.
4. Stop mid-read: stop asserted while in WAIT, then start issued 1 cycle later → late mem_valid data is discarded. The new playback's first sample equals the new start_addr byte.
5. Backpressure: FIFO_WORDS=4, length=64, rate_div=99 → mem_rd stops after 4 words. At most one read is outstanding at any time. All 64 bytes are emitted in order.
6. Reset mid-playback: reset asserted asynchronously → all outputs 0 on the same edge, and mem_rd stays deasserted until the next start.

Source files
------------

// File: rtl/wave_pkg.sv
// Shared types and helpers for the wave sample prefetcher.
// Fetch FSM encoding, word geometry and byte-to-PCM conversion.
package wave_pkg;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_REQ  = 2'd1,
    F_WAIT = 2'd2
  } fetch_e;

  localparam int BYTES_PER_WORD = 8;

  // Unsigned 8-bit PCM to signed 16-bit: flip the MSB, scale by 256.
  function automatic logic [15:0] u8_to_s16(input logic [7:0] b);
    return {~b[7], b[6:0], 8'h00};
  endfunction

endpackage

// File: rtl/wave_prefetch_if.sv
// DDR word-read port between the prefetcher and the memory arbiter.
// One read in flight; data returns as a single-cycle mem_valid beat.
interface wave_prefetch_if;
  logic        mem_rd;
  logic [24:0] mem_addr;
  logic        mem_busy;
  logic [63:0] mem_dout;
  logic        mem_valid;

  modport master (
    output mem_rd, mem_addr,
    input  mem_busy, mem_dout, mem_valid
  );

  modport slave (
    input  mem_rd, mem_addr,
    output mem_busy, mem_dout, mem_valid
  );
endinterface

// File: rtl/wave_word_fifo.sv
// First-word fall-through FIFO holding prefetched 64-bit DDR words.
// Head is combinational so the unpacker indexes it directly.
module wave_word_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [W-1:0]           din_i,
  input  logic                   pop_i,
  output logic [W-1:0]           dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [LW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop)  rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= din_i;
  end

  assign dout_o  = mem_q[rp_q];
  assign level_o = cnt_q;
  assign full_o  = (cnt_q == LW'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/wave_prefetch.sv
// Prefetches 8-bit PCM from DDR into a word FIFO and emits one
// signed 16-bit sample per divider tick.
module wave_prefetch
  import wave_pkg::*;
#(
  parameter int FIFO_WORDS = 4,
  parameter int DIV_W      = 16
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [27:0]      start_addr,
  input  logic [23:0]      length,
  input  logic [DIV_W-1:0] rate_div,
  wave_prefetch_if.master  mem,
  output logic [15:0]      sample,
  output logic             sample_stb,
  output logic             playing,
  output logic             done,
  output logic             underrun
);
  localparam int LW = $clog2(FIFO_WORDS) + 1;

  fetch_e           fst_q, fst_d;
  logic [24:0]      waddr_q, waddr_d;
  logic [21:0]      wleft_q, wleft_d;
  logic             drain_q, drain_d;
  logic             pend_q, pend_d;
  logic [27:0]      paddr_q, paddr_d;
  logic [23:0]      plen_q, plen_d;
  logic [2:0]       bidx_q, bidx_d;
  logic [23:0]      rem_q, rem_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             play_q, play_d;
  logic             stb_q, stb_d;
  logic             done_q, done_d;
  logic             unr_q, unr_d;
  logic [15:0]      smp_q, smp_d;

  logic [63:0]      head;
  logic             full, empty;
  logic [LW-1:0]    level;
  logic             push, pop, flush;
  logic             go, abort, accept;
  logic             inflight, launch, tick;
  logic [27:0]      l_addr;
  logic [23:0]      l_len;
  logic [21:0]      nwords;
  logic [7:0]       cur;

  wave_word_fifo #(
    .DEPTH(FIFO_WORDS),
    .W    (64)
  ) u_fifo (
    .clk    (clk_sys),
    .rst    (reset),
    .flush_i(flush),
    .push_i (push),
    .din_i  (mem.mem_dout),
    .pop_i  (pop),
    .dout_o (head),
    .full_o (full),
    .empty_o(empty),
    .level_o(level)
  );

  assign go     = start && !stop;
  assign abort  = start || stop;
  assign accept = (fst_q == F_REQ) && !mem.mem_busy;
  // A read accepted this cycle or still awaiting data blocks a restart.
  assign inflight = accept ||
    (((fst_q == F_WAIT) || drain_q) && !mem.mem_valid);
  assign launch = go ? !inflight
                     : (!abort && pend_q && !drain_q);
  assign l_addr = go ? start_addr : paddr_q;
  assign l_len  = go ? length : plen_q;
  assign nwords = 22'((25'(l_addr[2:0]) + 25'(l_len) + 25'd7) >> 3);
  assign tick   = play_q && (div_q >= rate_div);
  assign cur    = head[{bidx_q, 3'b000} +: 8];

  always_comb begin
    fst_d   = fst_q;
    waddr_d = waddr_q;
    wleft_d = wleft_q;
    drain_d = drain_q;
    pend_d  = pend_q;
    paddr_d = paddr_q;
    plen_d  = plen_q;
    bidx_d  = bidx_q;
    rem_d   = rem_q;
    div_d   = div_q;
    play_d  = play_q;
    unr_d   = unr_q;
    smp_d   = smp_q;
    stb_d   = 1'b0;
    done_d  = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;

    if (abort) begin
      flush   = 1'b1;
      fst_d   = F_IDLE;
      wleft_d = '0;
      play_d  = 1'b0;
      div_d   = '0;
      drain_d = inflight;
      pend_d  = go && inflight;
      if (go) begin
        paddr_d = start_addr;
        plen_d  = length;
      end
    end else begin
      if (drain_q && mem.mem_valid) drain_d = 1'b0;

      unique case (fst_q)
        F_IDLE: begin
          if (play_q && (wleft_q != '0) && !full && !drain_q)
            fst_d = F_REQ;
        end
        F_REQ: begin
          if (!mem.mem_busy) fst_d = F_WAIT;
        end
        F_WAIT: begin
          if (mem.mem_valid) begin
            push    = 1'b1;
            waddr_d = waddr_q + 25'd1;
            wleft_d = wleft_q - 22'd1;
            fst_d   = ((wleft_q != 22'd1) &&
                       (level < LW'(FIFO_WORDS - 1))) ? F_REQ : F_IDLE;
          end
        end
        default: fst_d = F_IDLE;
      endcase

      if (play_q) begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (tick) begin
          if (empty) begin
            unr_d = 1'b1;
          end else begin
            smp_d = u8_to_s16(cur);
            stb_d = 1'b1;
            rem_d = rem_q - 24'd1;
            if (rem_q == 24'd1) begin
              play_d = 1'b0;
              done_d = 1'b1;
              pop    = 1'b1;
            end else if (bidx_q == 3'(BYTES_PER_WORD - 1)) begin
              pop    = 1'b1;
              bidx_d = '0;
            end else begin
              bidx_d = bidx_q + 3'd1;
            end
          end
        end
      end
    end

    if (launch) begin
      pend_d  = 1'b0;
      waddr_d = l_addr[27:3];
      wleft_d = nwords;
      bidx_d  = l_addr[2:0];
      rem_d   = l_len;
      unr_d   = 1'b0;
      div_d   = '0;
      if (l_len != '0) begin
        play_d = 1'b1;
        fst_d  = F_REQ;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      fst_q   <= F_IDLE;
      waddr_q <= '0;
      wleft_q <= '0;
      drain_q <= 1'b0;
      pend_q  <= 1'b0;
      paddr_q <= '0;
      plen_q  <= '0;
      bidx_q  <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      play_q  <= 1'b0;
      stb_q   <= 1'b0;
      done_q  <= 1'b0;
      unr_q   <= 1'b0;
      smp_q   <= '0;
    end else begin
      fst_q   <= fst_d;
      waddr_q <= waddr_d;
      wleft_q <= wleft_d;
      drain_q <= drain_d;
      pend_q  <= pend_d;
      paddr_q <= paddr_d;
      plen_q  <= plen_d;
      bidx_q  <= bidx_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      play_q  <= play_d;
      stb_q   <= stb_d;
      done_q  <= done_d;
      unr_q   <= unr_d;
      smp_q   <= smp_d;
    end
  end

  assign mem.mem_rd   = (fst_q == F_REQ);
  assign mem.mem_addr = waddr_q;
  assign sample       = smp_q;
  assign sample_stb   = stb_q;
  assign playing      = play_q;
  assign done         = done_q;
  assign underrun     = unr_q;

endmodule
